reset_sequencer: RTL and testbench

- Parametrised multi-channel successor to the single-output reset-release delay.
- Releases N_CH downstream reset domains one after another. Channel 0 is released after an initial DELAY of enabled ticks; each later channel follows after STEP further ticks.
- Adds a software restart, busy/done status, stage reporting, and an optional acknowledge-gated handshake with timeout.
- Sits at the top level between the board reset/clock-enable and the subsystem reset inputs.

---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/reset_seq_cnt.sv | 26 ++
 rtl/reset_sequencer.sv | 138 +++++++++++++
 tb/tb_reset_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the sequenced reset-release block.
// Optional ack handshake is built when RESET_SEQ_ACK_EN is defined.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_STEP     = 3'd2,
    ST_ACK_WAIT = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } seq_state_t;

  function automatic int stage_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_seq_cnt.sv
// Enable-gated tick counter with synchronous clear and
// terminal-count compare, shared by all timed phases.
module reset_seq_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enb,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt;

  assign o_tc = i_enb && (cnt == i_term);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (i_enb) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_CH reset domains one after another.
// Define RESET_SEQ_ACK_EN for the ack-gated handshake with timeout.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int N_CH   = 4,
  parameter int DELAY  = 1023,
  parameter int STEP   = 255,
  parameter int ACK_TO = 511,
  localparam int STG_W = stage_w(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enb,
  input  logic             i_sw_rst,
  input  logic [N_CH-1:0]  i_ack,
  output logic [N_CH-1:0]  o_q,
  output logic             o_busy,
  output logic             o_done,
  output logic [STG_W-1:0] o_stage,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] T_DLY  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] T_STEP = CNT_W'(STEP - 1);
  localparam logic [CNT_W-1:0] T_ACK  = CNT_W'(ACK_TO - 1);
  localparam logic [N_CH-1:0]  Q_ONE  = N_CH'(1);
  localparam logic [STG_W-1:0] S_ONE  = STG_W'(1);
  localparam logic [STG_W-1:0] S_LAST = STG_W'(N_CH - 1);
  localparam logic [STG_W-1:0] S_ALL  = STG_W'(N_CH);

  seq_state_t       state;
  logic             counting;
  logic             cnt_en;
  logic             cnt_clr;
  logic             tc;
  logic             ack_evt;
  logic [CNT_W-1:0] term;

  assign counting = (state == ST_INIT) || (state == ST_STEP) ||
                    (state == ST_ACK_WAIT);
  assign cnt_en   = i_enb && counting;
  assign cnt_clr  = !counting || i_sw_rst || tc || ack_evt;

`ifdef RESET_SEQ_ACK_EN
  logic [N_CH-1:0] top_bit;
  // Highest released channel is the one awaiting its ack.
  assign top_bit = o_q & ~(o_q >> 1);
  assign ack_evt = (state == ST_ACK_WAIT) && i_enb &&
                   |(i_ack & top_bit);
`else
  logic ack_unused;
  assign ack_unused = ^i_ack;
  assign ack_evt    = 1'b0;
`endif

  always_comb begin
    term = T_STEP;
    unique case (1'b1)
      state == ST_INIT:     term = T_DLY;
      state == ST_ACK_WAIT: term = T_ACK;
      default:              term = T_STEP;
    endcase
  end

  reset_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_enb  (cnt_en),
    .i_clr  (cnt_clr),
    .i_term (term),
    .o_tc   (tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      o_q     <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_stage <= '0;
      o_err   <= 1'b0;
    end else if (i_sw_rst && state != ST_IDLE) begin
      state   <= ST_INIT;
      o_q     <= '0;
      o_busy  <= 1'b1;
      o_done  <= 1'b0;
      o_stage <= '0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state  <= ST_INIT;
          o_busy <= 1'b1;
        end
        ST_INIT, ST_STEP: begin
          if (tc) begin
            o_q     <= (o_q << 1) | Q_ONE;
            o_stage <= o_stage + S_ONE;
`ifdef RESET_SEQ_ACK_EN
            state   <= ST_ACK_WAIT;
`else
            if (o_stage == S_LAST) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state  <= ST_STEP;
            end
`endif
          end
        end
`ifdef RESET_SEQ_ACK_EN
        ST_ACK_WAIT: begin
          if (ack_evt) begin
            if (o_stage == S_ALL) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state  <= ST_STEP;
            end
          end else if (tc) begin
            state  <= ST_FAULT;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboarded random test of reset_sequencer against a tick model.
// Build with RESET_SEQ_ACK_EN to exercise the ack handshake.
module tb_reset_sequencer;

  localparam int N     = 4;
  localparam int DLY   = 8;
  localparam int STP   = 4;
  localparam int ATO   = 5;
  localparam int SW    = $clog2(N + 1);

  typedef struct packed {
    logic [N-1:0]  q;
    logic          busy;
    logic          done;
    logic [SW-1:0] stage;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enb;
  logic          sw;
  logic [N-1:0]  ack;
  logic [N-1:0]  q;
  logic          busy;
  logic          done;
  logic [SW-1:0] stage;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  bit m_started, m_wait, m_fault, m_done;
  int m_stage, m_el;

  always #5 clk = ~clk;

  reset_sequencer #(
    .CNT_W  (10),
    .N_CH   (N),
    .DELAY  (DLY),
    .STEP   (STP),
    .ACK_TO (ATO)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_enb    (enb),
    .i_sw_rst (sw),
    .i_ack    (ack),
    .o_q      (q),
    .o_busy   (busy),
    .o_done   (done),
    .o_stage  (stage),
    .o_err    (err)
  );

  // One clock edge of the reference behaviour, in elapsed-tick terms.
  function automatic void model_edge(bit r, bit e, bit s,
                                     logic [N-1:0] a);
    int need;
    if (r) begin
      m_started = 0; m_wait = 0; m_fault = 0; m_done = 0;
      m_stage = 0; m_el = 0;
    end else if (!m_started) begin
      m_started = 1; m_el = 0;
    end else if (s) begin
      m_wait = 0; m_fault = 0; m_done = 0;
      m_stage = 0; m_el = 0;
    end else if (e && !m_done && !m_fault) begin
      if (m_wait) begin
        if (a[m_stage-1]) begin
          m_wait = 0; m_el = 0;
          m_done = (m_stage == N);
        end else if (m_el + 1 == ATO) begin
          m_fault = 1; m_el = 0;
        end else begin
          m_el++;
        end
      end else begin
        need = (m_stage == 0) ? DLY : STP;
        if (m_el + 1 == need) begin
          m_stage++; m_el = 0;
`ifdef RESET_SEQ_ACK_EN
          m_wait = 1;
`else
          m_done = (m_stage == N);
`endif
        end else begin
          m_el++;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.q     = N'((1 << m_stage) - 1);
    x.busy  = m_started && !m_done && !m_fault;
    x.done  = m_done;
    x.stage = SW'(m_stage);
    x.err   = m_fault;
    return x;
  endfunction

  task automatic drive(bit r, bit e, bit s, logic [N-1:0] a);
    @(negedge clk);
    rst = r; enb = e; sw = s; ack = a;
    model_edge(r, e, s, a);
    sb.push_back(model_out());
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = '{q: q, busy: busy, done: done, stage: stage, err: err};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got q=%b busy=%b done=%b stage=%0d err=%b want q=%b busy=%b done=%b stage=%0d err=%b",
                   $time, got.q, got.busy, got.done, got.stage, got.err,
                   e.q, e.busy, e.done, e.stage, e.err);
        end
        n_checks++;
        if (((q & (q + N'(1))) != '0) || ($countones(q) != int'(stage))) begin
          n_fail++;
          $display("FAIL thermo t=%0t got q=%b stage=%0d want thermometer with popcount==stage",
                   $time, q, stage);
        end
      end
    end
  end

  initial begin
    rst = 1; enb = 1; sw = 0; ack = '0;
    model_edge(1, 1, 0, '0);

    do_reset(3);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, '0);

    do_reset(2);
    for (int i = 0; i < 90; i++) drive(0, (i % 3) == 0, 0, '0);

    do_reset(2);
    for (int i = 0; i < 40; i++) drive(0, 1, i == 14, '0);

    do_reset(2);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, '0);
    drive(1, 1, 1, '0);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, '0);

    do_reset(2);
    for (int i = 0; i < 40; i++) drive(0, 1, 0, '1);

    do_reset(2);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, '0);
    drive(0, 1, 1, '0);
    for (int i = 0; i < 40; i++) drive(0, 1, 0, '0);

    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 59) == 0,
            N'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
